// File: rtl/hid_uart_arbiter.sv
// Round-robin arbiter sharing one UART TX between the HID report printer (0)
// and the status/debug source (1); whole-message grants, idle gap, stall timeout.
module hid_uart_arbiter #(
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        abort,
    output logic        abort_id
);

    // state    | meaning
    // S_IDLE   | no owner, arbitrating among valid requesters
    // S_GRANT0 | requester 0 owns the UART until its last byte or timeout
    // S_GRANT1 | requester 1 owns the UART until its last byte or timeout
    // S_GAP    | forced idle gap between messages, requests ignored

    localparam int unsigned      GAP_W    = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
    localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [15:0]        tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               last_served_q, last_served_d;
    logic               abort_q, abort_d;
    logic               abort_id_q, abort_id_d;

    logic               in_grant;
    logic               owner;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;
    logic               out_free;
    logic               accept;
    logic               tmo_fire;
    logic               msg_end;

    assign in_grant  = (state_q == S_GRANT0) || (state_q == S_GRANT1);
    assign owner     = (state_q == S_GRANT1);
    assign own_valid = owner ? req_valid[1] : req_valid[0];
    assign own_last  = owner ? req_last[1]  : req_last[0];
    assign own_data  = owner ? req_data[15:8] : req_data[7:0];
    assign out_free  = ~tx_valid_q | tx_ready;
    assign accept    = in_grant & own_valid & out_free;
    // Fires on the idle cycle that brings the count up to TIMEOUT.
    assign tmo_fire  = in_grant & ~own_valid & (tmo_q == TMO_LAST);
    assign msg_end   = (accept & own_last) | tmo_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid == 2'b11) begin
                    state_d = last_served_q ? S_GRANT0 : S_GRANT1;
                end else if (req_valid[0]) begin
                    state_d = S_GRANT0;
                end else if (req_valid[1]) begin
                    state_d = S_GRANT1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (msg_end) begin
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant     = 2'b00;
        req_ready = 2'b00;
        case (state_q)
            S_GRANT0: begin
                grant        = 2'b01;
                req_ready[0] = accept;
            end
            S_GRANT1: begin
                grant        = 2'b10;
                req_ready[1] = accept;
            end
            default: begin
                grant     = 2'b00;
                req_ready = 2'b00;
            end
        endcase
        busy = (state_q != S_IDLE) | tx_valid_q;
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end

        // Only idle cycles of the owner count; a stalled UART with valid held does not.
        tmo_d = tmo_q;
        if (!in_grant || accept || tmo_fire) begin
            tmo_d = 16'd0;
        end else if (!own_valid) begin
            tmo_d = tmo_q + 16'd1;
        end

        gap_d = gap_q;
        if (state_q != S_GAP && state_d == S_GAP) begin
            gap_d = GAP_LOAD;
        end else if (state_q == S_GAP && gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        last_served_d = last_served_q;
        if (state_q == S_IDLE && state_d == S_GRANT0) begin
            last_served_d = 1'b0;
        end else if (state_q == S_IDLE && state_d == S_GRANT1) begin
            last_served_d = 1'b1;
        end

        abort_d    = tmo_fire;
        abort_id_d = tmo_fire ? owner : abort_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'd0;
            tmo_q         <= 16'd0;
            gap_q         <= '0;
            last_served_q <= 1'b1;
            abort_q       <= 1'b0;
            abort_id_q    <= 1'b0;
        end else begin
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            last_served_q <= last_served_d;
            abort_q       <= abort_d;
            abort_id_q    <= abort_id_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign abort    = abort_q;
    assign abort_id = abort_id_q;

endmodule

// File: tb/tb_hid_uart_arbiter.sv
// Bench for hid_uart_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a message-level reference model.
module tb_hid_uart_arbiter;

    localparam int TMO = 8;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_last = 2'b00;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic [1:0]  grant;
    logic        busy;
    logic        abort;
    logic        abort_id;

    always #5 clk = ~clk;

    hid_uart_arbiter #(.TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .abort(abort), .abort_id(abort_id)
    );

    typedef struct packed { logic [7:0] d; logic l; } bt_t;
    bt_t q0[$];
    bt_t q1[$];

    logic [1:0] hs = 2'b00;
    int  tx_mode = 0;           // 0 high, 1 toggle, 2 random, 3 low
    bit  rnd_valid = 0;
    int  pause0 = 0, pause1 = 0;
    int  n_checks = 0, n_errors = 0;
    bit  cmp_en = 0;

    // Reference model: owner (-1 none), remaining gap cycles, idle-cycle count.
    int         m_owner = -1;
    int         m_gap = 0;
    int         m_last = 1;
    int         m_stall = 0;
    logic       m_txv = 1'b0;
    logic [7:0] m_txd = 8'h00;
    logic       m_abort = 1'b0;
    logic       m_abort_id = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_ready();
        logic [1:0] r;
        r = 2'b00;
        if (m_owner >= 0 && req_valid[m_owner] && (!m_txv || tx_ready)) r[m_owner] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        logic [1:0] rdy;
        int o;
        bit leave;
        rdy = m_ready();
        if (reset) begin
            m_owner = -1; m_gap = 0; m_last = 1; m_stall = 0;
            m_txv = 1'b0; m_txd = 8'h00; m_abort = 1'b0; m_abort_id = 1'b0;
        end else begin
            o = m_owner;
            leave = 0;
            m_abort = 1'b0;
            if (o >= 0 && rdy[o]) begin
                m_txv = 1'b1;
                m_txd = req_data[8*o +: 8];
                m_stall = 0;
                if (req_last[o]) leave = 1;
            end else begin
                if (tx_ready) m_txv = 1'b0;
                if (o >= 0 && !req_valid[o]) begin
                    m_stall++;
                    if (m_stall == TMO) begin
                        m_abort = 1'b1;
                        m_abort_id = o[0];
                        leave = 1;
                    end
                end
            end
            if (o >= 0) begin
                if (leave) begin
                    m_owner = -1;
                    m_gap = GAP;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                if (req_valid == 2'b11) m_owner = 1 - m_last;
                else if (req_valid[0]) m_owner = 0;
                else if (req_valid[1]) m_owner = 1;
                if (m_owner >= 0) begin
                    m_last = m_owner;
                    m_stall = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] eg;
        if (cmp_en) begin
            eg = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
            chk("grant", 32'(grant), 32'(eg));
            chk("req_ready", 32'(req_ready), 32'(m_ready()));
            chk("tx_valid", 32'(tx_valid), 32'(m_txv));
            chk("tx_data", 32'(tx_data), 32'(m_txd));
            chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0) || m_txv));
            chk("abort", 32'(abort), 32'(m_abort));
            chk("abort_id", 32'(abort_id), 32'(m_abort_id));
        end
        hs = req_valid & req_ready;
    end

    always @(posedge clk) begin
        #1;
        if (hs[0] && q0.size() > 0) void'(q0.pop_front());
        if (hs[1] && q1.size() > 0) void'(q1.pop_front());
        if (rnd_valid) begin
            if (pause0 > 0) pause0--; else if ($urandom_range(0, 29) == 0) pause0 = $urandom_range(1, 12);
            if (pause1 > 0) pause1--; else if ($urandom_range(0, 29) == 0) pause1 = $urandom_range(1, 12);
        end else begin
            pause0 = 0;
            pause1 = 0;
        end
        req_valid[0] = (q0.size() > 0) && (pause0 == 0);
        req_valid[1] = (q1.size() > 0) && (pause1 == 0);
        if (q0.size() > 0) begin req_data[7:0] = q0[0].d; req_last[0] = q0[0].l; end
        else begin req_data[7:0] = 8'($urandom); req_last[0] = 1'($urandom); end
        if (q1.size() > 0) begin req_data[15:8] = q1[0].d; req_last[1] = q1[0].l; end
        else begin req_data[15:8] = 8'($urandom); req_last[1] = 1'($urandom); end
        case (tx_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            2: tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b0;
        endcase
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        bt_t e;
        e.d = d;
        e.l = l;
        if (r == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic push_msg(input int r, input int len);
        for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
    endtask

    task automatic rst_begin();
        reset = 1'b1;
        rnd_valid = 0;
        cyc(1);
        q0.delete();
        q1.delete();
    endtask

    task automatic rst_end();
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic wait_new_grant(output logic [1:0] g);
        logic [1:0] p;
        bit found;
        p = grant;
        g = 2'b00;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(1);
            if (grant != 2'b00 && p == 2'b00) begin
                g = grant;
                found = 1;
            end
            p = grant;
        end
    endtask

    initial begin
        logic [1:0] g;
        logic [7:0] got[$];
        bit abort_seen;
        int viol, arr;

        reset = 1'b1;
        cyc(1);
        cmp_en = 1;
        cyc(2);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_abort_id", 32'(abort_id), 0);
        reset = 1'b0;

        // single message
        tx_mode = 0;
        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h0A, 1);
        wait_new_grant(g);
        chk("t1_grant", 32'(g), 32'h1);
        cyc(1); chk("t1_b0_valid", 32'(tx_valid), 1); chk("t1_b0", 32'(tx_data), 32'h41);
        cyc(1); chk("t1_b1", 32'(tx_data), 32'h42);
        cyc(1); chk("t1_b2", 32'(tx_data), 32'h0A); chk("t1_grant_drop", 32'(grant), 0);
        cyc(3); chk("t1_busy_gap", 32'(busy), 1);
        cyc(1); chk("t1_busy_drop", 32'(busy), 0);

        // tie arbitration, alternation over four messages
        rst_begin();
        push_byte(0, 8'h10, 0); push_byte(0, 8'h11, 1);
        push_byte(1, 8'h20, 0); push_byte(1, 8'h21, 1);
        rst_end();
        wait_new_grant(g); chk("tie_1st", 32'(g), 32'h1);
        wait_new_grant(g); chk("tie_2nd", 32'(g), 32'h2);
        push_byte(0, 8'h30, 0); push_byte(0, 8'h31, 1);
        push_byte(1, 8'h40, 0); push_byte(1, 8'h41, 1);
        wait_new_grant(g); chk("tie_3rd", 32'(g), 32'h1);
        wait_new_grant(g); chk("tie_4th", 32'(g), 32'h2);

        // backpressure
        rst_begin();
        rst_end();
        tx_mode = 1;
        for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h50 + i), i == 4);
        abort_seen = 0;
        got.delete();
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (abort) abort_seen = 1;
        end
        tx_mode = 0;
        chk("bp_count", 32'(got.size()), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("bp_byte", 32'(got[i]), 32'(8'h50 + i));
        chk("bp_no_abort", 32'(abort_seen), 0);

        // timeout
        rst_begin();
        rst_end();
        push_byte(1, 8'h55, 0);
        wait_new_grant(g);
        chk("tmo_grant", 32'(g), 32'h2);
        push_byte(0, 8'h60, 0); push_byte(0, 8'h61, 1);
        cyc(8); chk("tmo_early", 32'(abort), 0); chk("tmo_hold", 32'(grant), 32'h2);
        cyc(1); chk("tmo_pulse", 32'(abort), 1); chk("tmo_id", 32'(abort_id), 1);
        chk("tmo_grant_drop", 32'(grant), 0);
        cyc(1); chk("tmo_once", 32'(abort), 0);
        cyc(3); chk("tmo_gap", 32'(grant), 0);
        cyc(1); chk("tmo_next", 32'(grant), 32'h1);

        // non-owner isolation
        rst_begin();
        rst_end();
        push_byte(0, 8'h70, 0); push_byte(0, 8'h71, 0); push_byte(0, 8'h72, 1);
        wait_new_grant(g);
        chk("iso_grant", 32'(g), 32'h1);
        push_byte(1, 8'h80, 1);
        viol = 0;
        arr = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (req_ready[1] && grant != 2'b10) viol++;
            if (grant == 2'b10 && arr == 0) arr = i;
        end
        chk("iso_viol", 32'(viol), 0);
        chk("iso_arrival", 32'(arr), 8);

        // reset mid-message
        rst_begin();
        rst_end();
        tx_mode = 3;
        push_byte(0, 8'h90, 0); push_byte(0, 8'h91, 0); push_byte(0, 8'h92, 1);
        wait_new_grant(g);
        chk("rm_grant", 32'(g), 32'h1);
        cyc(1); chk("rm_inflight", 32'(tx_valid), 1);
        reset = 1'b1;
        push_byte(1, 8'hA0, 1);
        cyc(1);
        chk("rm_txv", 32'(tx_valid), 0); chk("rm_grant0", 32'(grant), 0); chk("rm_idle", 32'(busy), 0);
        reset = 1'b0;
        tx_mode = 0;
        cyc(1); chk("rm_winner", 32'(grant), 32'h1);

        // randomized traffic
        rst_begin();
        rst_end();
        rnd_valid = 1;
        tx_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (q0.size() < 10) push_msg(0, $urandom_range(1, 5));
                end else begin
                    if (q1.size() < 10) push_msg(1, $urandom_range(1, 5));
                end
            end
        end
        rnd_valid = 0;
        tx_mode = 0;
        for (int i = 0; i < 400 && !(q0.size() == 0 && q1.size() == 0 && !busy); i++) cyc(1);
        chk("drain", 32'({q0.size() == 0, q1.size() == 0, busy}), 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
